// File: rtl/updown_pkg.sv
// rtl/updown_pkg.sv - shared types and parameter checks for the up/down step counter
package updown_pkg;

  typedef enum logic {CNT_WRAP = 1'b0, CNT_SAT = 1'b1} cnt_mode_e;

  function automatic bit params_ok(input int width, input int step_w, input int modulus);
    return (modulus >= 2) && (modulus <= (1 << width)) && (step_w <= width) &&
           (((1 << step_w) - 1) < modulus);
  endfunction

endpackage

// File: rtl/step_addsub.sv
// rtl/step_addsub.sv - combinational modulo/saturating add or subtract of a step
module step_addsub
  import updown_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int STEP_W  = 2,
  parameter int MODULUS = 2 ** WIDTH
) (
  input  logic [WIDTH-1:0]  cur,
  input  logic [STEP_W-1:0] step,
  input  logic              down,
  input  logic              mode,
  output logic [WIDTH-1:0]  nxt,
  output logic              wrap_ev,
  output logic              clamp_ev
);

  localparam logic [WIDTH:0] MOD_W = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0] TOP_W = MOD_W - 1'b1;

  logic [WIDTH:0] cur_x;
  logic [WIDTH:0] step_x;
  logic [WIDTH:0] sum_x;
  logic [WIDTH:0] res_x;
  logic           sat;

  assign cur_x  = {1'b0, cur};
  assign step_x = (WIDTH+1)'(step);
  assign sum_x  = cur_x + step_x;
  assign sat    = (mode == CNT_SAT);

  // Wrapping down is done as MOD - (step - cur) so it never needs a WIDTH+2 bit result.
  always_comb begin
    res_x    = cur_x;
    wrap_ev  = 1'b0;
    clamp_ev = 1'b0;
    if (!down) begin
      if (sum_x <= TOP_W) begin
        res_x = sum_x;
      end else if (sat) begin
        res_x    = TOP_W;
        clamp_ev = 1'b1;
      end else begin
        res_x   = sum_x - MOD_W;
        wrap_ev = 1'b1;
      end
    end else begin
      if (cur_x >= step_x) begin
        res_x = cur_x - step_x;
      end else if (sat) begin
        res_x    = '0;
        clamp_ev = 1'b1;
      end else begin
        res_x   = MOD_W - (step_x - cur_x);
        wrap_ev = 1'b1;
      end
    end
  end

  assign nxt = WIDTH'(res_x);

endmodule

// File: rtl/updown_step_counter.sv
// rtl/updown_step_counter.sv - registered up/down counter with run-time step, load and event flags
module updown_step_counter
  import updown_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int STEP_W  = 2,
  parameter int MODULUS = 2 ** WIDTH
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              en,
  input  logic              down,
  input  logic [STEP_W-1:0] step,
  input  logic              mode,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  output logic [WIDTH-1:0]  out,
  output logic              wrap,
  output logic              clamp
);

  localparam logic [WIDTH:0] TOP_W = (WIDTH+1)'(MODULUS) - 1'b1;

  if (!params_ok(WIDTH, STEP_W, MODULUS)) begin : g_param_err
    $error("updown_step_counter: illegal WIDTH/STEP_W/MODULUS combination");
  end

  logic [WIDTH-1:0] out_q, out_d;
  logic             wrap_q, wrap_d;
  logic             clamp_q, clamp_d;
  logic [WIDTH-1:0] nxt;
  logic             wrap_ev, clamp_ev;

  step_addsub #(
    .WIDTH  (WIDTH),
    .STEP_W (STEP_W),
    .MODULUS(MODULUS)
  ) u_addsub (
    .cur     (out_q),
    .step    (step),
    .down    (down),
    .mode    (mode),
    .nxt     (nxt),
    .wrap_ev (wrap_ev),
    .clamp_ev(clamp_ev)
  );

  always_comb begin
    out_d   = out_q;
    wrap_d  = 1'b0;
    clamp_d = 1'b0;
    if (load) begin
      out_d = ({1'b0, load_val} > TOP_W) ? WIDTH'(TOP_W) : load_val;
    end else if (en) begin
      out_d   = nxt;
      wrap_d  = wrap_ev;
      clamp_d = clamp_ev;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      out_q   <= '0;
      wrap_q  <= 1'b0;
      clamp_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      wrap_q  <= wrap_d;
      clamp_q <= clamp_d;
    end
  end

  assign out   = out_q;
  assign wrap  = wrap_q;
  assign clamp = clamp_q;

endmodule

// File: tb/tb_updown_step_counter.sv
// tb/tb_updown_step_counter.sv - directed and model-checked bench for updown_step_counter
module tb_updown_step_counter;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       en = 1'b0;
  logic       down = 1'b0;
  logic [1:0] step = 2'd0;
  logic       mode = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic [3:0] out;
  logic       wrap;
  logic       clamp;

  int total = 0;
  int bad = 0;

  updown_step_counter #(
    .WIDTH  (4),
    .STEP_W (2),
    .MODULUS(10)
  ) dut (
    .clk     (clk),
    .nrst    (nrst),
    .en      (en),
    .down    (down),
    .step    (step),
    .mode    (mode),
    .load    (load),
    .load_val(load_val),
    .out     (out),
    .wrap    (wrap),
    .clamp   (clamp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic expect3(input string tag, input int o, input int w, input int c);
    chk({tag, ".out"}, 32'(out), o);
    chk({tag, ".wrap"}, 32'(wrap), w);
    chk({tag, ".clamp"}, 32'(clamp), c);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic d, input logic [1:0] s, input logic m,
                       input logic l, input logic [3:0] lv);
    en = e; down = d; step = s; mode = m; load = l; load_val = lv;
    tick();
  endtask

  int r_out, r_w, r_c, sum;
  logic       rd, rm;
  logic [1:0] rs;

  initial begin
    #12;
    expect3("reset", 0, 0, 0);
    @(negedge clk);
    nrst = 1'b1;
    tick();

    // Reset mid-count
    drive(0, 0, 0, 0, 1, 4'd7);
    expect3("load7", 7, 0, 0);
    #2 nrst = 1'b0;
    #1 expect3("async_rst", 0, 0, 0);
    tick();
    expect3("rst_held", 0, 0, 0);
    nrst = 1'b1;
    drive(1, 0, 1, 0, 0, 4'd0);
    expect3("post_rst1", 1, 0, 0);
    tick();
    expect3("post_rst2", 2, 0, 0);
    tick();
    expect3("post_rst3", 3, 0, 0);

    // Up wrap
    drive(0, 0, 0, 0, 1, 4'd8);
    expect3("load8", 8, 0, 0);
    drive(1, 0, 3, 0, 0, 4'd0);
    expect3("up_wrap", 1, 1, 0);
    tick();
    expect3("up_after_wrap", 4, 0, 0);

    // Up saturate
    drive(0, 0, 0, 0, 1, 4'd8);
    drive(1, 0, 3, 1, 0, 4'd0);
    expect3("up_sat", 9, 0, 1);
    tick();
    expect3("up_sat_again", 9, 0, 1);
    drive(0, 0, 3, 1, 0, 4'd0);
    expect3("sat_hold", 9, 0, 0);

    // Down wrap / saturate
    drive(0, 0, 0, 0, 1, 4'd1);
    drive(1, 1, 2, 0, 0, 4'd0);
    expect3("down_wrap", 9, 1, 0);
    drive(0, 0, 0, 0, 1, 4'd1);
    expect3("load_clears", 1, 0, 0);
    drive(1, 1, 2, 1, 0, 4'd0);
    expect3("down_sat", 0, 0, 1);

    // Load priority and limiting
    drive(1, 0, 3, 0, 1, 4'd12);
    expect3("load_limit", 9, 0, 0);
    drive(1, 1, 3, 1, 1, 4'd5);
    expect3("load5", 5, 0, 0);

    // Hold cases
    drive(1, 0, 0, 0, 0, 4'd0);
    expect3("hold_step0", 5, 0, 0);
    drive(0, 1, 3, 0, 0, 4'd0);
    expect3("hold_en0", 5, 0, 0);

    // Random up/down against a reference model
    r_out = 5;
    for (int i = 0; i < 20; i++) begin
      rd = 1'($urandom_range(0, 1));
      rm = 1'($urandom_range(0, 1));
      rs = 2'($urandom_range(0, 3));
      r_w = 0;
      r_c = 0;
      if (!rd) begin
        sum = r_out + int'(rs);
        if (sum <= 9) r_out = sum;
        else if (rm) begin r_out = 9; r_c = 1; end
        else begin r_out = sum - 10; r_w = 1; end
      end else begin
        if (r_out >= int'(rs)) r_out = r_out - int'(rs);
        else if (rm) begin r_out = 0; r_c = 1; end
        else begin r_out = r_out + 10 - int'(rs); r_w = 1; end
      end
      drive(1, rd, rs, rm, 0, 4'd0);
      expect3($sformatf("rand%0d", i), r_out, r_w, r_c);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/updown_step_counter.md
Name: updown_step_counter

Overview:
Parametrised synchronous up/down counter that advances by a run-time step.
- Counting range is 0..MODULUS-1, so the width and modulus are generic, and decimal or other non-power-of-two counts are supported.
- Adds over a fixed step-1/step-2 counter: selectable wrap/saturate mode, parallel load, count enable, and registered event flags.
- Serves as the general counter primitive for timers, dividers and address generators in the lab designs.

Parameters:
- WIDTH, 8, counter width in bits.
- STEP_W, 2, width of the step input.
- MODULUS, 2**WIDTH, number of counter states; the count range is 0..MODULUS-1.
- Elaboration-time checks: 2 <= MODULUS <= 2**WIDTH, STEP_W <= WIDTH, and 2**STEP_W - 1 < MODULUS.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- nrst  in  1  asynchronous reset, active-low.
- en  in  1  count enable.
- down  in  1  direction: 0 = up, 1 = down.
- step  in  STEP_W  unsigned increment/decrement amount.
- mode  in  1  0 = wrap (modulo MODULUS), 1 = saturate.
- load  in  1  synchronous parallel load.
- load_val  in  WIDTH  value to load.
- out  out  WIDTH  current count (registered).
- wrap  out  1  registered pulse: the last update wrapped.
- clamp  out  1  registered pulse: the last update saturated.

Behaviour:
- Reset: nrst low forces out = 0, wrap = 0 and clamp = 0 immediately, independent of clk. These values are held while nrst is low. The first update happens on the first rising clk edge after nrst goes high.
- Priority at each rising edge: load > en > hold.
- Load:
  - If load_val <= MODULUS-1, out <= load_val; otherwise out <= MODULUS-1.
  - wrap and clamp are both cleared, including when load_val was out of range.
  - The en, down, step and mode inputs are ignored that cycle.
- Hold: when en = 0, or en = 1 with step = 0, out is unchanged and wrap = clamp = 0.
- Up count (en = 1, down = 0, step = s > 0). Compute sum = out + s at WIDTH+1 bits.
  - If sum <= MODULUS-1: out <= sum.
  - Else, mode = 0: out <= sum - MODULUS and wrap <= 1.
  - Else, mode = 1: out <= MODULUS-1 and clamp <= 1.
  - Clamp is flagged even if out was already MODULUS-1.
- Down count (en = 1, down = 1, step = s > 0).
  - If out >= s: out <= out - s.
  - Else, mode = 0: out <= out + MODULUS - s and wrap <= 1.
  - Else, mode = 1: out <= 0 and clamp <= 1.
- Flags:
  - wrap and clamp are registered alongside out.
  - Each is high for exactly the cycle after the edge that caused the event, and is cleared on every edge without an event.
  - wrap and clamp are never both high.
- Latency: one cycle from inputs to out and flags. There are no combinational paths from inputs to outputs.
- All arithmetic is unsigned. Because of the parameter checks, no intermediate result exceeds WIDTH+1 bits and a single wrap correction always suffices.
- Changing mode, down or step between cycles takes effect on the next edge; no pipeline state is carried.
- If nrst is asserted in the middle of a run, the counter restarts from 0 with flags clear. Pending events are discarded.

Decomposition:
- Package updown_pkg: typedef enum logic {CNT_WRAP = 1'b0, CNT_SAT = 1'b1} cnt_mode_e, plus any helper function for the range checks.
- Sub-module step_addsub (combinational). Inputs: cur, step, down, mode. Outputs: nxt, wrap_ev, clamp_ev. It contains all modulo and saturation arithmetic.
- The top level holds only the registers, load/enable priority and load_val range limiting.

Test Plan:
All scenarios use WIDTH = 4, STEP_W = 2, MODULUS = 10.
- Reset mid-count: with out = 7, drop nrst between edges -> out = 0, wrap = 0, clamp = 0 before the next edge; after release with up/step = 1 -> out sequence 1, 2, 3.
- Up wrap: load 8, then en = 1, down = 0, step = 3, mode = 0 -> out = 1 with wrap = 1 for one cycle. Next edge -> out = 4, wrap = 0.
- Up saturate: load 8, step = 3, mode = 1 -> out = 9, clamp = 1. Next edge with the same inputs -> out = 9, clamp = 1. Then en = 0 -> out = 9, clamp = 0.
- Down wrap/saturate: from 1, down = 1, step = 2, mode = 0 -> out = 9, wrap = 1. From 1 with mode = 1 -> out = 0, clamp = 1.
- Load priority and limiting: load = 1, en = 1, load_val = 12 -> out = 9, no flags. Then load_val = 5 -> out = 5.
- Hold cases: en = 1 with step = 0 -> out unchanged, no flags. en = 0 with step = 3 -> out unchanged, no flags. Run 20 random up/down steps and compare out and the flags against a reference model.
